// File: rtl/pulse_stretch_multi_pkg.sv
// Shared definitions for the multi-channel pulse stretcher.
//   state_t    : per-channel FSM encoding (IDLE / STRETCH / HOLDOFF)
//   clog2      : ceiling log2 for elaboration-time sizing
//   cnt_width  : counter width wide enough for both stretch and holdoff loads
package pulse_stretch_multi_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STRETCH = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int cnt_width(input int len_w, input int holdoff_cyc);
    int hw;
    hw = clog2(holdoff_cyc) + 1;
    return (len_w > hw) ? len_w : hw;
  endfunction

endpackage

// File: rtl/pulse_stretch_multi_chan.sv
// One channel of the pulse stretcher: edge detect, IDLE/STRETCH/HOLDOFF FSM,
// down-counter and sticky missed-trigger flag.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   in_pulse      : trigger input (synchronous to clk)
//   ch_en         : channel enable, 0 forces IDLE on the next edge
//   stretch_len   : stretch length, sampled on the trigger edge (0 behaves as 1)
//   retrig        : 1 = trigger during STRETCH reloads the length
//   missed_clr    : synchronous clear of the missed flag (wins over a set)
//   out_pulse     : registered stretched output
//   busy          : registered, high in STRETCH or HOLDOFF
//   missed        : sticky ignored-trigger flag
module pulse_stretch_multi_chan
  import pulse_stretch_multi_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int HOLDOFF_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic             ch_en,
  input  logic [LEN_W-1:0] stretch_len,
  input  logic             retrig,
  input  logic             missed_clr,
  output logic             out_pulse,
  output logic             busy,
  output logic             missed
);

  localparam int CNT_W = cnt_width(LEN_W, HOLDOFF_CYC);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF_CYC > 0) ? CNT_W'(HOLDOFF_CYC - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             missed_q, missed_d;
  logic             prev_q;
  logic             trig;
  logic             miss_set;
  logic [LEN_W-1:0] len_m1;
  logic [CNT_W-1:0] len_load;

  // A zero length is treated as one cycle, so the load value saturates at 0.
  assign len_m1   = (stretch_len == '0) ? '0 : (stretch_len - 1'b1);
  assign len_load = CNT_W'(len_m1);

  // prev_q tracks the raw input even while disabled, so re-enabling with the
  // input already high does not produce a trigger.
  assign trig = in_pulse & ~prev_q & ch_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    busy_d   = busy_q;
    miss_set = 1'b0;
    if (!ch_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      out_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_d  = 1'b0;
          busy_d = 1'b0;
          if (trig) begin
            state_d = S_STRETCH;
            cnt_d   = len_load;
            out_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
        S_STRETCH: begin
          if (trig && retrig) begin
            // Reload wins even on the final cycle of the stretch.
            cnt_d = len_load;
          end else begin
            miss_set = trig;
            if (cnt_q == '0) begin
              out_d = 1'b0;
              if (HOLDOFF_CYC > 0) begin
                state_d = S_HOLDOFF;
                cnt_d   = HOLD_LOAD;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        S_HOLDOFF: begin
          miss_set = trig;
          out_d    = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
    missed_d = missed_clr ? 1'b0 : (missed_q | miss_set);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
      // Start high so an input already asserted at reset release is not an edge.
      prev_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
      prev_q   <= in_pulse;
    end
  end

  assign out_pulse = out_q;
  assign busy      = busy_q;
  assign missed    = missed_q;

endmodule

// File: rtl/pulse_stretch_multi.sv
// N-channel pulse stretcher with retrigger mode, post-stretch holdoff,
// per-channel enable and sticky missed-trigger flags.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   in_pulse      : [N_CH] trigger inputs, synchronous to clk
//   ch_en         : [N_CH] per-channel enable
//   stretch_len   : [LEN_W] shared stretch length, sampled per channel at trigger
//   retrig        : shared retrigger mode
//   missed_clr    : shared synchronous clear of all missed flags
//   out_pulse     : [N_CH] stretched outputs
//   busy          : [N_CH] channel in STRETCH or HOLDOFF
//   missed        : [N_CH] sticky ignored-trigger flags
module pulse_stretch_multi
  import pulse_stretch_multi_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int LEN_W       = 8,
  parameter int HOLDOFF_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_pulse,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [LEN_W-1:0] stretch_len,
  input  logic             retrig,
  input  logic             missed_clr,
  output logic [N_CH-1:0]  out_pulse,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  missed
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pulse_stretch_multi_chan #(
      .LEN_W       (LEN_W),
      .HOLDOFF_CYC (HOLDOFF_CYC)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .in_pulse    (in_pulse[g]),
      .ch_en       (ch_en[g]),
      .stretch_len (stretch_len),
      .retrig      (retrig),
      .missed_clr  (missed_clr),
      .out_pulse   (out_pulse[g]),
      .busy        (busy[g]),
      .missed      (missed[g])
    );
  end

endmodule
